// File: rtl/lif_pkg.sv
// Shared types, constants and arithmetic helper for the LIF time-multiplexed scheduler.
package lif_pkg;

    localparam int LIF_W_DEF  = 8;
    localparam int LIF_N_DEF  = 4;
    localparam int THRESH_RST = 127;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } lif_state_e;

    // Unsigned add of two values, clamped to the largest w-bit value (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [31:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
        return (sum > {1'b0, lim}) ? lim : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_tdm_scheduler_update.sv
// Single-neuron leaky-integrate-and-fire update: halve the state, add the
// input current with saturation, fire and reset when the threshold is reached.
module lif_update
    import lif_pkg::*;
#(
    parameter int W = LIF_W_DEF
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] state,
    input  logic [W-1:0] thresh,
    output logic [W-1:0] nxt_state,
    output logic         fire
);

    logic [31:0] sat;

    // Saturated sum never exceeds 2^W-1, so the upper bits only matter for the compare.
    assign sat       = sat_add(32'(cur), 32'(state >> 1), W);
    assign fire      = (sat >= 32'(thresh));
    assign nxt_state = fire ? '0 : sat[W-1:0];

endmodule

// File: rtl/lif_tdm_scheduler.sv
// Sweeps all neurons through one shared LIF datapath per timestep and
// publishes the complete spike vector in a single cycle at the end of the sweep.
module lif_tdm_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS = LIF_N_DEF,
    parameter int W         = LIF_W_DEF,
    parameter int AW        = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cur_we,
    input  logic [AW-1:0]        cur_addr,
    input  logic [W-1:0]         cur_data,
    input  logic [W-1:0]         thresh,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spikes,
    output logic [7:0]           step_count,
    input  logic [AW-1:0]        rd_addr,
    output logic [W-1:0]         rd_state
);

    lif_state_e            st;
    lif_state_e            st_nxt;
    logic [W-1:0]          state_q [N_NEURONS];
    logic [W-1:0]          cur_q   [N_NEURONS];
    logic [AW-1:0]         idx;
    logic [N_NEURONS-1:0]  spk_acc;
    logic [N_NEURONS-1:0]  acc_nxt;
    logic [W-1:0]          thresh_q;
    logic                  accept;
    logic                  last;
    logic [W-1:0]          upd_state;
    logic                  upd_fire;

    lif_update #(.W(W)) u_update (
        .cur       (cur_q[idx]),
        .state     (state_q[idx]),
        .thresh    (thresh_q),
        .nxt_state (upd_state),
        .fire      (upd_fire)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) st <= S_IDLE;
        else        st <= st_nxt;
    end

    // FSM next state: start only counts in IDLE; the last neuron ends the sweep.
    always_comb begin
        st_nxt = st;
        case (st)
            S_IDLE:  if (start) st_nxt = S_RUN;
            S_RUN:   if (last)  st_nxt = S_IDLE;
            default: st_nxt = S_IDLE;
        endcase
    end

    // FSM outputs and sweep qualifiers.
    always_comb begin
        busy   = (st == S_RUN);
        accept = (st == S_IDLE) && start;
        last   = (st == S_RUN) && (idx == AW'(N_NEURONS - 1));
    end

    // Accumulator with the neuron being processed this cycle merged in, so the
    // published vector includes the final neuron's bit.
    always_comb begin
        acc_nxt      = spk_acc;
        acc_nxt[idx] = upd_fire;
    end

    // Sweep datapath: index, state update, spike accumulation and publication.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            spk_acc    <= '0;
            thresh_q   <= W'(THRESH_RST);
            spikes     <= '0;
            done       <= 1'b0;
            step_count <= '0;
            for (int i = 0; i < N_NEURONS; i++) state_q[i] <= '0;
        end else begin
            done <= last;
            if (accept) begin
                thresh_q <= thresh;
                idx      <= '0;
                spk_acc  <= '0;
            end else if (busy) begin
                state_q[idx] <= upd_state;
                spk_acc      <= acc_nxt;
                idx          <= idx + AW'(1);
                if (last) begin
                    spikes     <= acc_nxt;
                    step_count <= step_count + 8'd1;
                end
            end
        end
    end

    // Current register file; a write to the neuron being processed lands after
    // the datapath has already consumed the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) cur_q[i] <= '0;
        end else if (cur_we) begin
            cur_q[cur_addr] <= cur_data;
        end
    end

    // Registered state readback (pre-update value on a same-cycle update).
    always_ff @(posedge clk) begin
        if (!rst_n) rd_state <= '0;
        else        rd_state <= state_q[rd_addr];
    end

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Self-checking bench: a per-neuron arithmetic model predicts every output each
// cycle; directed scenarios add hand-computed literal expectations.
module tb_lif_tdm_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cur_we = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [W-1:0]  cur_data = '0;
    logic [W-1:0]  thresh = 8'd127;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [N-1:0]  spikes;
    logic [7:0]    step_count;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_state;

    int checks = 0;
    int errors = 0;

    lif_tdm_scheduler #(.N_NEURONS(N), .W(W), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cur_we     (cur_we),
        .cur_addr   (cur_addr),
        .cur_data   (cur_data),
        .thresh     (thresh),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .spikes     (spikes),
        .step_count (step_count),
        .rd_addr    (rd_addr),
        .rd_state   (rd_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    int m_state [N];
    int m_cur   [N];
    int m_acc   [N];
    int m_thr;
    int m_pos;          // neuron to process this cycle, -1 when no sweep
    int m_valid = 0;
    int e_spikes, e_step, e_rd;
    bit e_done, e_busy;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_state[i] = 0; m_cur[i] = 0; m_acc[i] = 0;
            end
            m_thr = 127; m_pos = -1;
            e_spikes = 0; e_step = 0; e_rd = 0; e_done = 0; e_busy = 0;
            m_valid = 1;
        end else if (m_valid != 0) begin
            int k, s, rd_next;
            bit dn;
            rd_next = m_state[int'(rd_addr)];
            dn = 0;
            if (m_pos >= 0) begin
                k = m_pos;
                s = m_cur[k] + m_state[k] / 2;
                if (s > 255) s = 255;
                if (s >= m_thr) begin m_state[k] = 0; m_acc[k] = 1; end
                else            begin m_state[k] = s; m_acc[k] = 0; end
                if (k == N - 1) begin
                    e_spikes = 0;
                    for (int i = 0; i < N; i++) e_spikes += m_acc[i] << i;
                    e_step = (e_step + 1) % 256;
                    dn = 1;
                    m_pos = -1;
                end else begin
                    m_pos = k + 1;
                end
            end else if (start) begin
                m_thr = int'(thresh);
                for (int i = 0; i < N; i++) m_acc[i] = 0;
                m_pos = 0;
            end
            if (cur_we) m_cur[int'(cur_addr)] = int'(cur_data);
            e_rd = rd_next;
            e_done = dn;
            e_busy = (m_pos >= 0);
        end
    end

    // Compare process: every output, every cycle once reset has been applied.
    always @(negedge clk) begin
        if (m_valid != 0) begin
            checks += 5;
            if (busy !== e_busy) begin
                errors++; $display("FAIL model busy: actual %0b required %0b at %0t", busy, e_busy, $time);
            end
            if (done !== e_done) begin
                errors++; $display("FAIL model done: actual %0b required %0b at %0t", done, e_done, $time);
            end
            if (spikes !== N'(e_spikes)) begin
                errors++; $display("FAIL model spikes: actual %b required %b at %0t", spikes, N'(e_spikes), $time);
            end
            if (step_count !== 8'(e_step)) begin
                errors++; $display("FAIL model step_count: actual %0d required %0d at %0t", step_count, e_step, $time);
            end
            if (rd_state !== W'(e_rd)) begin
                errors++; $display("FAIL model rd_state: actual %0d required %0d at %0t", rd_state, e_rd, $time);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cur(input int a, input int d);
        cur_we = 1'b1; cur_addr = AW'(a); cur_data = W'(d);
        tick();
        cur_we = 1'b0;
    endtask

    // Returns cycles from the start cycle to the cycle in which done is high.
    task automatic sweep(output int lat);
        start = 1'b1;
        lat = 0;
        while (1) begin
            tick();
            lat++;
            if (lat == 1) start = 1'b0;
            if (done) break;
            if (lat >= 30) begin
                chk("sweep done timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic read_state(input int a, output int v);
        rd_addr = AW'(a);
        tick();
        v = int'(rd_state);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin tick(); n++; end
        if (!done) chk("wait done timeout", 0, 1);
    endtask

    initial begin
        int lat, v, n;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset defaults
        chk("reset spikes", int'(spikes), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset step_count", int'(step_count), 0);
        chk("reset rd_state", int'(rd_state), 0);

        // Idle sweep with zero currents
        thresh = 8'd127;
        sweep(lat);
        chk("done latency", lat, 5);
        chk("idle sweep spikes", int'(spikes), 0);
        tick();
        chk("done one pulse", int'(done), 0);

        // Integrate then fire
        write_cur(0, 100);
        write_cur(1, 200);
        sweep(lat);
        chk("integrate spikes s1", int'(spikes), 4'b0010);
        read_state(0, v);
        chk("integrate state0 s1", v, 100);
        sweep(lat);
        chk("integrate spikes s2", int'(spikes), 4'b0011);
        read_state(0, v);
        chk("integrate state0 s2", v, 0);
        write_cur(0, 0);
        write_cur(1, 0);

        // Saturation
        thresh = 8'd255;
        write_cur(2, 200);
        sweep(lat);
        chk("sat spikes s1", int'(spikes), 0);
        read_state(2, v);
        chk("sat state2 s1", v, 200);
        sweep(lat);
        chk("sat spikes s2", int'(spikes), 4'b0100);
        read_state(2, v);
        chk("sat state2 s2", v, 0);
        write_cur(2, 0);
        chk("step after 5 sweeps", int'(step_count), 5);

        // Start held high: back-to-back sweeps every N+1 cycles
        thresh = 8'd127;
        start = 1'b1;
        n = 0;
        repeat (16) begin
            tick();
            if (done) n++;
        end
        start = 1'b0;
        chk("held start done count", n, 3);
        wait_done();
        chk("held start step_count", int'(step_count), 9);
        tick();
        chk("busy after held start", int'(busy), 0);

        // Start pulsed mid-RUN is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        repeat (10) begin
            tick();
            if (done) n++;
        end
        chk("mid-run start ignored", n, 1);
        chk("busy stays low", int'(busy), 0);

        // thresh = 0: everyone fires
        thresh = 8'd0;
        sweep(lat);
        chk("thresh0 spikes", int'(spikes), 4'b1111);
        thresh = 8'd127;

        // Write collision on neuron 3 (processed on the 4th edge after acceptance)
        start = 1'b1;
        n = 0;
        while (1) begin
            tick();
            n++;
            if (n == 1) start = 1'b0;
            if (n == 4) begin cur_we = 1'b1; cur_addr = 2'd3; cur_data = 8'd255; end
            if (n == 5) cur_we = 1'b0;
            if (done || n >= 30) break;
        end
        chk("collision sweep spikes", int'(spikes), 0);
        read_state(3, v);
        chk("collision state3", v, 0);
        sweep(lat);
        chk("collision next spikes", int'(spikes), 4'b1000);
        write_cur(3, 0);

        // Reset mid-sweep
        write_cur(0, 100);
        sweep(lat);
        read_state(0, v);
        chk("pre-reset state0", v, 100);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            tick();
            if (done) n++;
        end
        chk("reset mid-sweep no done", n, 0);
        chk("reset mid-sweep spikes", int'(spikes), 0);
        chk("reset mid-sweep step", int'(step_count), 0);
        for (int i = 0; i < N; i++) begin
            read_state(i, v);
            chk("reset mid-sweep state", v, 0);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lif_tdm_scheduler.md
# lif_tdm_scheduler

Time-multiplexing controller that shares one leaky-integrate-and-fire update datapath across `N_NEURONS` neurons. It stores each neuron's membrane state and input current, sweeps all neurons once per timestep on a `start` pulse, and publishes the resulting spike vector atomically at the end of the sweep. It is the sequencing layer above the single-neuron LIF update, which computes `state/2 + current` and compares the result against a threshold.

## Interface
- `N_NEURONS`, default 4: neurons multiplexed onto the datapath (≥2, power of 2).
- `W`, default 8: width of state, current and threshold.
- `AW`, default `$clog2(N_NEURONS)`: neuron address width.

- `clk` input 1: clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `cur_we` input 1: write strobe for the current register file.
- `cur_addr` input AW: neuron index for the current write.
- `cur_data` input W: current value to write.
- `thresh` input W: spike threshold, sampled when `start` is accepted.
- `start` input 1: request one timestep sweep.
- `busy` output 1: sweep in progress.
- `done` output 1: one-cycle pulse marking the end of a sweep.
- `spikes` output N_NEURONS: spike vector from the last completed sweep.
- `step_count` output 8: completed sweeps, wraps 255→0.
- `rd_addr` input AW: state readback address.
- `rd_state` output W: registered state of neuron `rd_addr`.

## Operation
- **Storage:** `state[N]` and `cur[N]` register arrays.
- **Current writes:** accepted every cycle regardless of `busy`.
- **FSM states:** IDLE and RUN.
  - IDLE→RUN when `start` is high. This latches `thresh` into `thresh_q`, clears `idx` and clears `spk_acc`.
  - `start` is ignored while in RUN.
- **RUN, per cycle, neuron `idx`:**
  - `sum = cur[idx] + (state[idx] >> 1)`, computed W+1 bits wide and saturated to 2^W−1 to give `nxt`.
  - `fire = (nxt >= thresh_q)`.
  - `state[idx] <= fire ? 0 : nxt`.
  - `spk_acc[idx] <= fire`.
  - `idx <= idx+1`.
- **End of sweep:** when `idx == N_NEURONS-1`, the FSM goes to IDLE, `spikes <=` `spk_acc` including the final neuron's bit, `done <= 1`, and `step_count` increments.
- **Write/read collision:** a `cur_we` to neuron k in the same cycle that k is processed is written, but the update uses the old `cur[k]`. The new value applies from the next sweep.
- **`thresh = 0`:** every neuron fires every sweep, and all states stay 0.
- **Readback:** `rd_state <= state[rd_addr]` every cycle. It returns the pre-update value if `rd_addr` is being written in that cycle.
- **Reset:**
  - `state`, `cur`, `spikes`, `spk_acc`, `step_count`, `rd_state`, `idx` clear to 0.
  - `done` and `busy` clear to 0.
  - `thresh_q` resets to 127.
  - The FSM returns to IDLE.
  - Reset during RUN abandons the sweep: no `done`, and `spikes` reads 0.

## Timing
- Let `start` be sampled high in cycle t while in IDLE.
- `busy` is high in cycles t+1 through t+N_NEURONS. In cycle t+1+i the FSM processes neuron i.
- In cycle t+N_NEURONS+1:
  - `done` is high, `busy` is low.
  - `spikes` and `step_count` carry the new values.
- A `start` sampled in the `done` cycle is accepted, giving back-to-back sweeps with a period of N_NEURONS+1 cycles.
- `spikes` is stable between `done` pulses and never shows a partial vector.
- `rd_state` latency is 1 cycle.

## Structure
- **Package `lif_pkg`:**
  - FSM state enum (`S_IDLE`, `S_RUN`).
  - `THRESH_RST = 127`.
  - Default `W` and `N_NEURONS`.
  - Saturating-add function.
- **Sub-module `lif_update`:** combinational. Inputs `cur`, `state`, `thresh`; outputs `nxt_state` (post-spike, 0 on fire) and `fire`.
- **`lif_tdm_scheduler` itself:** FSM, index counter, register arrays, spike accumulator, step counter and readback.

## Test plan
- **Reset defaults:** after reset, `spikes=0`, `busy=0`, `done=0`, `step_count=0`, `rd_state=0`. With `thresh=127` and all currents 0, one sweep gives `done` at t+5 (N=4) and `spikes=0000`.
- **Integrate then fire:** `cur[0]=100`, `thresh=127`. Sweep 1: `state[0]=100`, `spikes[0]=0`. Sweep 2: 100+50=150 fires, `spikes[0]=1`, `state[0]=0`. Simultaneously `cur[1]=200` fires on sweep 1.
- **Saturation:** `thresh=255`, `cur[2]=200`. Sweep 1: `state=200`, no spike. Sweep 2: 200+100 saturates to 255 and fires, `spikes=0100`.
- **Start handling:** `start` held high continuously gives `done` every 5 cycles and `step_count` 0→1→2→3. A `start` pulsed mid-RUN is ignored.
- **Write collision:** `cur_we` to neuron 3 with value 255 in the cycle neuron 3 is processed (old value 0). That sweep leaves `state[3]=0`; the next sweep fires neuron 3.
- **Reset mid-sweep:** `rst_n` low in cycle t+2 gives no `done`, with `spikes`, `state[*]` and `step_count` all 0 afterwards.
